// File: rtl/arm_bus_slave_regs_pkg.sv
// Shared definitions for the ARM926 mezzanine bus register slave:
// register indices, address window mask, FSM states and the byte-merge helper.
package arm_bus_pkg;

    localparam logic [31:0] ID_DEFAULT   = 32'h453A_0001;

    localparam logic [2:0]  REG_ID       = 3'd0;
    localparam logic [2:0]  REG_SCR1     = 3'd1;
    localparam logic [2:0]  REG_IRQ_STAT = 3'd2;
    localparam logic [2:0]  REG_IRQ_EN   = 3'd3;
    localparam logic [2:0]  REG_CTRL     = 3'd4;
    localparam logic [2:0]  REG_STATUS   = 3'd5;
    localparam logic [2:0]  REG_SCR6     = 3'd6;
    localparam logic [2:0]  REG_SCR7     = 3'd7;

    // Any address bit set under this mask lies outside the 8-word window.
    localparam logic [23:0] WIN_MASK     = 24'hFF_FFE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } bus_state_t;

    // Replace only the bytes whose active-low enable is asserted.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be_b);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be_b[i] ? old_val[8*i +: 8] : new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/arm_bus_slave_regs_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// reset value so an active-low strobe can come out of reset inactive.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage shift into the local clock; reset forces both stages inactive.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/arm_bus_slave_regs.sv
// ARM926 mezzanine bus register slave: synchronizes CS/OE, decodes an 8-word
// window, performs byte-enabled writes and registered reads, acknowledges with
// DTACK and raises a maskable, edge-triggered interrupt.
module arm_bus_slave_regs
    import arm_bus_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_DEFAULT,
    parameter int          IRQ_W    = 8
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RST_N,
    input  logic             ARM_CS_B,
    input  logic             ARM_OE_B,
    input  logic             ARM_RW,
    input  logic [23:0]      ARM_A,
    input  logic [3:0]       ARM_BE_B,
    input  logic [31:0]      ARM_D_IN,
    output logic [31:0]      ARM_D_OUT,
    output logic             ARM_D_OE,
    output logic             ARM_DTACK,
    output logic             ARM_IRQ,
    output logic [31:0]      CTRL_OUT,
    input  logic [31:0]      STATUS_IN,
    input  logic [IRQ_W-1:0] IRQ_SRC
);

    logic             w_cs_s;
    logic             w_oe_s;

    bus_state_t       r_state;
    bus_state_t       w_state_next;

    logic [23:0]      r_addr;
    logic             r_rw;
    logic [3:0]       r_be_b;
    logic [31:0]      r_wdata;

    logic [31:0]      r_scratch [0:2];
    logic [31:0]      r_ctrl;
    logic [IRQ_W-1:0] r_irq_en;
    logic [IRQ_W-1:0] r_irq_stat;
    logic [IRQ_W-1:0] r_irq_prev;
    logic             r_irq;
    logic [31:0]      r_d_out;

    logic [2:0]       w_idx;
    logic             w_in_win;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_scr_hit;
    logic [1:0]       w_scr_sel;
    logic [31:0]      w_rd_data;
    logic [IRQ_W-1:0] w_irq_rise;
    logic [IRQ_W-1:0] w_w1c;
    logic [IRQ_W-1:0] w_en_merged;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk   (SYS_CLK),
        .i_rst_n (SYS_RST_N),
        .i_d     (ARM_CS_B),
        .o_q     (w_cs_s)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_oe (
        .i_clk   (SYS_CLK),
        .i_rst_n (SYS_RST_N),
        .i_d     (ARM_OE_B),
        .o_q     (w_oe_s)
    );

    assign w_idx      = r_addr[4:2];
    assign w_in_win   = ((r_addr & WIN_MASK) == 24'h0);
    assign w_wr_en    = (r_state == ACCESS) && !r_rw && w_in_win;
    assign w_rd_en    = (r_state == ACCESS) && r_rw;
    assign w_irq_rise = IRQ_SRC & ~r_irq_prev;

    // Per-bit W1C clear mask and byte-merged IRQ_EN value; bit gi belongs to byte gi/8.
    for (genvar gi = 0; gi < IRQ_W; gi++) begin : g_irq_bits
        assign w_w1c[gi]       = w_wr_en && (w_idx == REG_IRQ_STAT) && !r_be_b[gi/8] && r_wdata[gi];
        assign w_en_merged[gi] = r_be_b[gi/8] ? r_irq_en[gi] : r_wdata[gi];
    end

    // FSM state register.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: one cycle in ACCESS, then hold ACK until the strobe releases.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!w_cs_s) w_state_next = ACCESS;
            ACCESS:  w_state_next = ACK;
            ACK:     if (w_cs_s) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Capture the address phase once, at the first synchronized CS low.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            r_addr  <= 24'h0;
            r_rw    <= 1'b0;
            r_be_b  <= 4'hF;
            r_wdata <= 32'h0;
        end else if (r_state == IDLE && !w_cs_s) begin
            r_addr  <= ARM_A;
            r_rw    <= ARM_RW;
            r_be_b  <= ARM_BE_B;
            r_wdata <= ARM_D_IN;
        end
    end

    // Map the three scratch words onto a compact array.
    always_comb begin
        w_scr_hit = 1'b0;
        w_scr_sel = 2'd0;
        case (w_idx)
            REG_SCR1: begin w_scr_hit = 1'b1; w_scr_sel = 2'd0; end
            REG_SCR6: begin w_scr_hit = 1'b1; w_scr_sel = 2'd1; end
            REG_SCR7: begin w_scr_hit = 1'b1; w_scr_sel = 2'd2; end
            default:  begin w_scr_hit = 1'b0; w_scr_sel = 2'd0; end
        endcase
    end

    // Read multiplexer; anything outside the window reads as zero.
    always_comb begin
        w_rd_data = 32'h0;
        if (w_in_win) begin
            case (w_idx)
                REG_ID:       w_rd_data = ID_VALUE;
                REG_IRQ_STAT: w_rd_data = 32'(r_irq_stat);
                REG_IRQ_EN:   w_rd_data = 32'(r_irq_en);
                REG_CTRL:     w_rd_data = r_ctrl;
                REG_STATUS:   w_rd_data = STATUS_IN;
                default:      w_rd_data = r_scratch[w_scr_sel];
            endcase
        end
    end

    // RW register file: commits only in ACCESS, so a reset before then drops the write.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            for (int i = 0; i < 3; i++) begin
                r_scratch[i] <= 32'h0;
            end
            r_ctrl   <= 32'h0;
            r_irq_en <= '0;
        end else if (w_wr_en) begin
            if (w_scr_hit) begin
                r_scratch[w_scr_sel] <= be_merge(r_scratch[w_scr_sel], r_wdata, r_be_b);
            end
            if (w_idx == REG_CTRL) begin
                r_ctrl <= be_merge(r_ctrl, r_wdata, r_be_b);
            end
            if (w_idx == REG_IRQ_EN) begin
                r_irq_en <= w_en_merged;
            end
        end
    end

    // Interrupt status: rising edges set, W1C clears, a coincident edge wins.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            r_irq_prev <= '0;
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_prev <= IRQ_SRC;
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_irq_rise;
            r_irq      <= |(r_irq_stat & r_irq_en);
        end
    end

    // Read data is registered on the same edge that enters ACK.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            r_d_out <= 32'h0;
        end else if (w_rd_en) begin
            r_d_out <= w_rd_data;
        end
    end

    assign ARM_D_OUT = r_d_out;
    assign ARM_DTACK = (r_state == ACK);
    assign ARM_D_OE  = (r_state == ACK) && r_rw && !w_oe_s;
    assign ARM_IRQ   = r_irq;
    assign CTRL_OUT  = r_ctrl;

endmodule

// File: tb/tb_arm_bus_slave_regs.sv
// Self-checking bench for arm_bus_slave_regs: directed register-map, IRQ and
// reset scenarios followed by randomized accesses against a register-level model.
module tb_arm_bus_slave_regs;

    localparam logic [31:0] ID = 32'h453A_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_b;
    logic        oe_b;
    logic        rw;
    logic [23:0] a;
    logic [3:0]  be_b;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        d_oe;
    logic        dtack;
    logic        irq;
    logic [31:0] ctrl_out;
    logic [31:0] status_in;
    logic [7:0]  irq_src;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: one word per register index plus IRQ bytes.
    logic [31:0] m_reg [8];
    logic [7:0]  m_en;
    logic [7:0]  m_stat;

    always #5 clk = ~clk;

    arm_bus_slave_regs #(.ID_VALUE(ID), .IRQ_W(8)) dut (
        .SYS_CLK   (clk),
        .SYS_RST_N (rst_n),
        .ARM_CS_B  (cs_b),
        .ARM_OE_B  (oe_b),
        .ARM_RW    (rw),
        .ARM_A     (a),
        .ARM_BE_B  (be_b),
        .ARM_D_IN  (d_in),
        .ARM_D_OUT (d_out),
        .ARM_D_OE  (d_oe),
        .ARM_DTACK (dtack),
        .ARM_IRQ   (irq),
        .CTRL_OUT  (ctrl_out),
        .STATUS_IN (status_in),
        .IRQ_SRC   (irq_src)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
        m_en   = 8'h0;
        m_stat = 8'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? old_v[8*i +: 8] : new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] addr);
        if (addr[23:5] != 19'h0) return 32'h0;
        case (addr[4:2])
            3'd0:    return ID;
            3'd2:    return {24'h0, m_stat};
            3'd3:    return {24'h0, m_en};
            3'd5:    return status_in;
            default: return m_reg[addr[4:2]];
        endcase
    endfunction

    task automatic model_write(input logic [23:0] addr, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] clr;
        logic [31:0] en_w;
        if (addr[23:5] != 19'h0) return;
        case (addr[4:2])
            3'd1, 3'd4, 3'd6, 3'd7: m_reg[addr[4:2]] = merge(m_reg[addr[4:2]], wd, be);
            3'd2: begin
                clr    = merge(32'h0, wd, be);
                m_stat = m_stat & ~clr[7:0];
            end
            3'd3: begin
                en_w = merge({24'h0, m_en}, wd, be);
                m_en = en_w[7:0];
            end
            default: ;
        endcase
    endtask

    // Full bus cycle: assert CS, check DTACK timing, data and OE gating, then release.
    task automatic bus_access(input logic rw_i, input logic [23:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [7:0] irq_e2,
                              output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic [7:0]  rise;
        @(posedge clk); #1;
        a = addr; rw = rw_i; be_b = be; d_in = wd; cs_b = 1'b0; oe_b = ~rw_i;
        exp_rd = model_read(addr);
        repeat (3) @(posedge clk);
        #1;
        rise    = irq_e2 & ~irq_src;
        irq_src = irq_e2;
        @(negedge clk);
        chk("dtack_before_e3", dtack, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("dtack_at_e3", dtack, 1'b1);
        chk("d_oe_at_e3", d_oe, rw_i);
        if (rw_i) chk("rdata", d_out, exp_rd);
        else      model_write(addr, be, wd);
        m_stat = m_stat | rise;
        chk("ctrl_at_e3", ctrl_out, m_reg[4]);
        rd = d_out;
        if (rw_i) begin
            oe_b = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("d_oe_gated", d_oe, 1'b0);
        end
        @(posedge clk); #1;
        cs_b = 1'b1; oe_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("dtack_hold", dtack, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("dtack_release", dtack, 1'b0);
        chk("d_oe_release", d_oe, 1'b0);
        chk("irq_level", irq, |(m_stat & m_en));
        $display("txn %s a=%06h be_b=%h wd=%08h rd=%08h irq=%0b", rw_i ? "RD" : "WR",
                 addr, be, wd, rd, irq);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [23:0] addr;
        logic [7:0]  nv;
        logic [7:0]  e2;

        rst_n = 1'b0; cs_b = 1'b1; oe_b = 1'b1; rw = 1'b1; a = 24'h0;
        be_b = 4'hF; d_in = 32'h0; status_in = 32'hCAFE_F00D; irq_src = 8'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dtack", dtack, 1'b0);
        chk("rst_d_oe", d_oe, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ctrl", ctrl_out, 32'h0);
        chk("rst_d_out", d_out, 32'h0);
        rst_n = 1'b1;

        // Register map basics
        bus_access(1'b1, 24'h000000, 4'h0, 32'h0, irq_src, rd);
        chk("id_value", rd, ID);
        bus_access(1'b0, 24'h000004, 4'h0, 32'h1122_3344, irq_src, rd);
        bus_access(1'b0, 24'h000004, 4'b1010, 32'hA5A5_A5A5, irq_src, rd);
        bus_access(1'b1, 24'h000004, 4'h0, 32'h0, irq_src, rd);
        chk("byte_merge", rd, 32'h11A5_33A5);
        bus_access(1'b0, 24'h000010, 4'h0, 32'h0000_00FF, irq_src, rd);
        chk("ctrl_out", ctrl_out, 32'h0000_00FF);
        bus_access(1'b0, 24'h000014, 4'h0, 32'hDEAD_BEEF, irq_src, rd);
        bus_access(1'b1, 24'h000014, 4'h0, 32'h0, irq_src, rd);
        chk("status_ro", rd, 32'hCAFE_F00D);
        bus_access(1'b0, 24'h000000, 4'h0, 32'hFFFF_FFFF, irq_src, rd);
        bus_access(1'b1, 24'h000000, 4'h0, 32'h0, irq_src, rd);
        chk("id_ro", rd, ID);

        // Out-of-window accesses
        bus_access(1'b0, 24'h000044, 4'h0, 32'h1234_5678, irq_src, rd);
        bus_access(1'b1, 24'h000040, 4'h0, 32'h0, irq_src, rd);
        chk("oow_read", rd, 32'h0);
        bus_access(1'b1, 24'h000004, 4'h0, 32'h0, irq_src, rd);
        chk("oow_no_write", rd, 32'h11A5_33A5);

        // Interrupt path
        bus_access(1'b0, 24'h00000C, 4'h0, 32'h0000_0001, irq_src, rd);
        @(posedge clk); #1;
        irq_src = 8'h01; m_stat = m_stat | 8'h01;
        @(negedge clk);
        chk("irq_edge_n", irq, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("irq_edge_n1", irq, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("irq_edge_n2", irq, 1'b1);
        irq_src = 8'h00;
        bus_access(1'b0, 24'h000008, 4'h0, 32'h0000_0001, irq_src, rd);
        chk("irq_w1c", irq, 1'b0);
        bus_access(1'b0, 24'h000008, 4'h0, 32'h0000_0001, 8'h01, rd);
        bus_access(1'b1, 24'h000008, 4'h0, 32'h0, irq_src, rd);
        chk("irq_set_wins", rd, 32'h0000_0001);
        @(negedge clk);
        irq_src = 8'h00;

        // Reset during ACK of a read, CS held low afterwards is a new access
        @(posedge clk); #1;
        a = 24'h0; rw = 1'b1; be_b = 4'h0; cs_b = 1'b0; oe_b = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_dtack", dtack, 1'b1);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack_dtack", dtack, 1'b0);
        chk("rst_ack_d_oe", d_oe, 1'b0);
        chk("rst_ack_irq", irq, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reacc_dtack_lo", dtack, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("reacc_dtack_hi", dtack, 1'b1);
        chk("reacc_data", d_out, ID);
        @(posedge clk); #1;
        cs_b = 1'b1; oe_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reacc_release", dtack, 1'b0);

        // Reset while a write sits in ACCESS: nothing may be committed
        @(posedge clk); #1;
        a = 24'h000010; rw = 1'b0; be_b = 4'h0; d_in = 32'h0000_0055; cs_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; cs_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ctrl", ctrl_out, 32'h0);
        chk("abort_dtack", dtack, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        bus_access(1'b1, 24'h000010, 4'h0, 32'h0, irq_src, rd);
        chk("abort_readback", rd, 32'h0);

        // Randomized accesses
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                nv      = 8'($urandom);
                m_stat  = m_stat | (nv & ~irq_src);
                irq_src = nv;
            end
            addr = {19'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) addr[23:5] = 19'($urandom_range(1, 19'h7FFFF));
            e2        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_src;
            status_in = $urandom;
            bus_access(1'($urandom), addr, 4'($urandom), $urandom, e2, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
